crc_byte_feeder: RTL and testbench
==================================

CRC_BYTE_FEEDER -- requirements
Module: crc_byte_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31, meaning max cycles waited in WAIT for crc_vld (range 17..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_data, input, 8, byte to be CRC'd.
REQ-005 SHALL have port in_valid, input, 1, in_data valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a byte.
REQ-007 SHALL have port ser_din, output, 1, serial bit to the CRC engine din.
REQ-008 SHALL have port ser_vld, output, 1, serial bit valid to the CRC engine din_vld.
REQ-009 SHALL have port crc_clr, output, 1, one-cycle clear pulse to the CRC engine clr.
REQ-010 SHALL have port crc_in, input, 8, CRC engine dout.
REQ-011 SHALL have port crc_vld, input, 1, CRC engine dout_vld.
REQ-012 SHALL have port out_data, output, 8, original byte of the result.
REQ-013 SHALL have port out_crc, output, 8, captured CRC-8 (poly 0x107).
REQ-014 SHALL have port out_err, output, 1, result produced by timeout, not by crc_vld.
REQ-015 SHALL have port out_valid, output, 1, result valid.
REQ-016 SHALL have port out_ready, input, 1, downstream accepts result.

Function
REQ-017 SHALL implement FSM states IDLE, CLR, SHIFT, WAIT, HOLD; all outputs registered or decoded from registered state only.
REQ-018 IDLE: in_ready=1; on in_valid=1, SHALL capture in_data into shift register and move to CLR next cycle.
REQ-019 CLR: crc_clr=1 for exactly one cycle, in_ready=0; SHALL then enter SHIFT with bit counter=0.
REQ-020 SHIFT: ser_vld=1 for exactly 8 consecutive cycles; ser_din = bit 7 first (MSB first) down to bit 0; then WAIT.
REQ-021 ser_din SHALL be 0 whenever ser_vld=0.
REQ-022 WAIT: ser_vld=0; on crc_vld=1 SHALL capture crc_in into out_crc, set out_err=0, move to HOLD.
REQ-023 crc_vld asserted in IDLE, CLR, SHIFT or HOLD SHALL be ignored.
REQ-024 HOLD: out_valid=1 with out_data/out_crc/out_err stable; on out_ready=1 SHALL return to IDLE next cycle (out_valid drops).
REQ-025 in_ready SHALL be 0 in every state except IDLE; no byte accepted while a result is held.
REQ-026 Wait counter SHALL be 8 bits, cleared on entry to WAIT, incrementing each WAIT cycle.
REQ-027 Latency in_valid accept to first ser_vld SHALL be 2 cycles; back-to-back bytes SHALL be separated by at least one IDLE cycle.

Reset
REQ-028 rst=1 SHALL, at the next clk edge, force IDLE and clear: in_ready=1 (after reset), ser_din=0, ser_vld=0, crc_clr=0, out_data=0, out_crc=0, out_err=0, out_valid=0, counters=0.
REQ-029 rst mid-SHIFT or mid-WAIT SHALL abort the byte with no result produced; a crc_vld arriving after the abort SHALL be ignored.

Configuration
REQ-030 Macro CRC_FEEDER_TIMEOUT_EN defined: when wait counter reaches TIMEOUT with no crc_vld, SHALL go to HOLD with out_crc=0x00, out_err=1.
REQ-031 Macro CRC_FEEDER_TIMEOUT_EN undefined: wait counter and out_err logic absent, out_err tied 0, WAIT persists until crc_vld.

Verification
REQ-032 in_data=0xA5 accepted in IDLE -> crc_clr pulse next cycle, then ser_din 1,0,1,0,0,1,0,1 with ser_vld=1 for 8 cycles.
REQ-033 With real CRC engine attached, in_data=0x01 -> out_valid=1, out_data=0x01, out_crc=0x07, out_err=0.
REQ-034 Result held with out_ready=0 for 10 cycles, in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> IDLE next cycle, byte accepted one cycle later.
REQ-035 Timeout build, crc_vld never asserted -> HOLD after 31 WAIT cycles, out_crc=0x00, out_err=1.
REQ-036 rst pulsed on 4th SHIFT cycle, crc_vld pulsed 20 cycles later -> all outputs at reset values, out_valid never asserts.
REQ-037 crc_vld=1, crc_in=0xFF during SHIFT, then crc_vld=1, crc_in=0x5A in WAIT -> out_crc=0x5A.

Source files
------------

// File: rtl/crc_byte_feeder.sv
// rtl/crc_byte_feeder.sv - serializes one byte MSB-first into a bit-serial CRC-8 engine and holds the result.
// Optional wait timeout enabled by defining CRC_FEEDER_TIMEOUT_EN.
module crc_byte_feeder #(
    parameter int TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ser_din,
    output logic       ser_vld,
    output logic       crc_clr,
    input  logic [7:0] crc_in,
    input  logic       crc_vld,
    output logic [7:0] out_data,
    output logic [7:0] out_crc,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic [7:0] r_crc;
    logic [2:0] r_bit;
    logic       w_crc_hit;
    logic       w_timeout;

    // crc_vld only means something while waiting; elsewhere it is stale or foreign
    assign w_crc_hit = (r_state == S_WAIT) && crc_vld;

`ifdef CRC_FEEDER_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_err;

    // r_wait idles at zero outside WAIT, so it enters WAIT cleared; TIMEOUT WAIT cycles max
    assign w_timeout = (r_state == S_WAIT) && !crc_vld && (r_wait == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_wait <= 8'd0;
            end else begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_crc_hit) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign out_err   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CLR;
            S_CLR:   w_next = S_SHIFT;
            S_SHIFT: if (r_bit == 3'd7) w_next = S_WAIT;
            S_WAIT:  if (w_crc_hit || w_timeout) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= 8'd0;
            r_data  <= 8'd0;
            r_crc   <= 8'd0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_data  <= in_data;
                    end
                end
                S_CLR: begin
                    r_bit <= 3'd0;
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_bit   <= r_bit + 3'd1;
                end
                S_WAIT: begin
                    if (w_crc_hit) begin
                        r_crc <= crc_in;
                    end else if (w_timeout) begin
                        r_crc <= 8'h00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign crc_clr   = (r_state == S_CLR);
    assign ser_vld   = (r_state == S_SHIFT);
    assign ser_din   = ser_vld & r_shift[7];
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_data;
    assign out_crc   = r_crc;

endmodule

// File: tb/tb_crc_byte_feeder.sv
// tb/tb_crc_byte_feeder.sv - randomized self-checking bench for crc_byte_feeder.
module tb_crc_byte_feeder;

    localparam int TIMEOUT = 31;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_din;
    logic       ser_vld;
    logic       crc_clr;
    logic [7:0] crc_in;
    logic       crc_vld;
    logic [7:0] out_data;
    logic [7:0] out_crc;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    int n_total = 0;
    int n_bad   = 0;

    crc_byte_feeder #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_din   (ser_din),
        .ser_vld   (ser_vld),
        .crc_clr   (crc_clr),
        .crc_in    (crc_in),
        .crc_vld   (crc_vld),
        .out_data  (out_data),
        .out_crc   (out_crc),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // CRC-8, poly x^8+x^2+x+1, zero init: remainder of b * x^8 divided by 0x107
    function automatic logic [7:0] crc_ref(input logic [7:0] b);
        logic [15:0] r;
        r = {b, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_ser_din"}, ser_din, 1'b0);
        chk({tag, "_ser_vld"}, ser_vld, 1'b0);
        chk({tag, "_crc_clr"}, crc_clr, 1'b0);
        chk({tag, "_out_data"}, out_data, 8'h00);
        chk({tag, "_out_crc"}, out_crc, 8'h00);
        chk({tag, "_out_err"}, out_err, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Accept a byte; returns at the first SHIFT cycle
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk("clr_pulse", crc_clr, 1'b1);
        chk("clr_in_ready", in_ready, 1'b0);
        chk("clr_ser_vld", ser_vld, 1'b0);
        tick();
    endtask

    // Eight SHIFT cycles; optionally a stray crc_vld mid-shift
    task automatic shift_phase(input logic [7:0] b, input logic early);
        logic [7:0] bits;
        int         nv;
        bits = 8'h00;
        nv   = 0;
        for (int i = 0; i < 8; i++) begin
            if (ser_vld) nv++;
            bits = {bits[6:0], ser_din};
            if (early && i == 3) begin
                crc_vld = 1'b1;
                crc_in  = 8'hFF;
            end
            tick();
            crc_vld = 1'b0;
        end
        chk("shift_vld_cycles", nv, 8);
        chk("shift_bits", bits, b);
        chk("wait_ser_vld", ser_vld, 1'b0);
        chk("wait_ser_din", ser_din, 1'b0);
        chk("wait_crc_clr", crc_clr, 1'b0);
    endtask

    task automatic run_byte(input logic [7:0] b, input logic early, input logic [7:0] crc_val,
                            input int delay, input int hold, input logic keep_valid);
        logic [7:0] held_crc;
        send_byte(b);
        shift_phase(b, early);
        repeat (delay) tick();
        chk("wait_no_result", out_valid, 1'b0);
        crc_vld = 1'b1;
        crc_in  = crc_val;
        tick();
        crc_vld = 1'b0;
        crc_in  = 8'($urandom);
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, b);
        chk("hold_crc", out_crc, crc_val);
        chk("hold_err", out_err, 1'b0);
        held_crc = out_crc;
        for (int i = 0; i < hold; i++) begin
            in_valid = keep_valid ? 1'b1 : 1'($urandom);
            in_data  = 8'($urandom);
            crc_vld  = 1'($urandom);
            tick();
            crc_vld = 1'b0;
            chk("hold_stay_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_crc_stable", out_crc, held_crc);
            chk("hold_data_stable", out_data, b);
        end
        if (!keep_valid) in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", out_valid, 1'b0);
        chk("release_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        int         seen;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        crc_in    = 8'h00;
        crc_vld   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        run_byte(8'hA5, 1'b0, crc_ref(8'hA5), 3, 0, 1'b0);
        run_byte(8'h01, 1'b0, crc_ref(8'h01), 0, 1, 1'b0);
        chk("crc_ref_01", crc_ref(8'h01), 8'h07);
        run_byte(8'h3C, 1'b1, 8'h5A, 2, 2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            b = 8'($urandom);
            run_byte(b, 1'($urandom), crc_ref(b), $urandom_range(0, 20), $urandom_range(0, 5), 1'b0);
        end

        // Long hold with a byte pending: accepted only after IDLE is reached
        in_data = 8'h77;
        run_byte(8'h96, 1'b0, crc_ref(8'h96), 1, 10, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("pending_accept_clr", crc_clr, 1'b1);
        do_reset();
        check_reset_outputs("reset2");

        // Reset on the 4th SHIFT cycle, then a late crc_vld
        send_byte(8'hC3);
        repeat (3) tick();
        chk("abort_in_shift", ser_vld, 1'b1);
        do_reset();
        check_reset_outputs("abort");
        repeat (19) tick();
        crc_vld = 1'b1;
        crc_in  = 8'hAA;
        tick();
        crc_vld = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort_no_result", seen, 0);
        check_reset_outputs("abort_late");

        // Reset in WAIT
        send_byte(8'h5E);
        shift_phase(8'h5E, 1'b0);
        tick();
        do_reset();
        crc_vld = 1'b1;
        crc_in  = 8'h33;
        tick();
        crc_vld = 1'b0;
        check_reset_outputs("abort_wait");

`ifdef CRC_FEEDER_TIMEOUT_EN
        send_byte(8'h81);
        shift_phase(8'h81, 1'b0);
        seen = 0;
        while (!out_valid && seen < 300) begin
            seen++;
            tick();
        end
        chk("timeout_cycles", seen, TIMEOUT);
        chk("timeout_valid", out_valid, 1'b1);
        chk("timeout_crc", out_crc, 8'h00);
        chk("timeout_err", out_err, 1'b1);
        chk("timeout_data", out_data, 8'h81);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("timeout_release", in_ready, 1'b1);
        b = 8'h42;
        run_byte(b, 1'b0, crc_ref(b), 5, 1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
